alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Sequencer and bus reader on the ALU side of the shared 8-bit CPU bus.
- Loads operands A and B off the bus into the registers that feed the ALU's reg_A/reg_B inputs, and drives the ALU's sel for one execute cycle.
- Then enables the ALU onto the bus and captures the result back off it.
- Detects divide-by-zero and bypasses the ALU in that case.

Parameters:
WIDTH, 8, data/bus width in bits

Ports:
clk  input  1  system clock, all state on rising edge
clr  input  1  synchronous active-high reset
start  input  1  one-cycle request to run an operation; sampled only in IDLE
op  input  2  operation code, latched with start: 00 ADD, 01 SUB, 10 MLT, 11 DIV
bus_in  input  WIDTH  read side of the shared bus
bus_valid  input  1  bus_in holds valid data this cycle
req_a  output  1  requests operand A on the bus (high in LD_A)
req_b  output  1  requests operand B on the bus (high in LD_B)
reg_A  output  WIDTH  operand A register, to ALU
reg_B  output  WIDTH  operand B register, to ALU
alu_sel  output  2  operation select to ALU
alu_en  output  1  ALU bus-drive enable (high only in RD)
result  output  WIDTH  captured result, held until next capture
done  output  1  one-cycle pulse: result valid
div_zero  output  1  sticky flag: last op was DIV with B==0
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (clr high at a rising edge, any state, mid-operation included):
  - state goes to IDLE.
  - reg_A, reg_B, result, alu_sel, op latch all go to 0.
  - done, div_zero, req_a, req_b, alu_en, busy all go to 0.
  - clr has priority over every other input.
- FSM states: IDLE, LD_A, LD_B, EXEC, RD. All outputs except done/div_zero/result are decoded from state.
- IDLE:
  - start=1 latches op into an internal register and moves to LD_A.
  - start=0 stays in IDLE.
- LD_A:
  - req_a=1.
  - If bus_valid=1: reg_A<=bus_in and go to LD_B.
  - Otherwise wait indefinitely; no timeout.
- LD_B:
  - req_b=1.
  - If bus_valid=1: reg_B<=bus_in.
  - Then, if latched op==DIV and bus_in==0: result<={WIDTH{1'b1}}, div_zero<=1, done<=1, go to IDLE (ALU bypassed).
  - Otherwise go to EXEC.
- EXEC:
  - alu_sel=latched op, alu_en=0.
  - Exactly one cycle; the ALU registers its result on the edge that leaves EXEC.
  - Then go to RD.
- RD:
  - alu_sel=latched op, alu_en=1.
  - result<=bus_in, done<=1, div_zero<=0, then go to IDLE.
  - bus_valid is ignored in RD; the ALU is the driver.
- alu_sel:
  - Holds the latched op in every state after IDLE, so the ALU's per-cycle recompute stays consistent.
  - Returns to 0 only on clr.
- Output stability:
  - reg_A and reg_B hold their values between operations.
  - result holds until the next capture.
- done is high exactly one cycle; it is never high while busy=1 from a new start.
- Latency with bus_valid high throughout:
  - start at edge 0 → done high in the cycle following edge 4 (5 cycles).
  - Divide-by-zero path: done follows edge 2.
- Arithmetic is performed by the ALU, modulo 2^WIDTH; this block captures its bus value unmodified.
- start while busy=1 is ignored.
- start asserted in the same cycle done is high is accepted, because state is IDLE.
- A bus_valid pulse in IDLE, EXEC or RD has no effect on the operand registers.

Test Plan:
- Reset mid-op: start op=00, A=0x12 loaded, clr in LD_B → next cycle busy=0, reg_A=0, reg_B=0, result=0, done=0, state IDLE.
- ADD: start op=00, bus A=0x2C, B=0x15 with bus_valid always 1, ALU model attached → alu_en high one cycle, done 5 cycles after start, result=0x41, div_zero=0.
- Wrap: SUB A=0x03 B=0x05 → result=0xFE. MLT A=0x10 B=0x11 → result=0x10.
- Divide-by-zero: op=11, A=0x40, B=0x00 → done 3 cycles after start, result=0xFF, div_zero=1, alu_en never high. Next DIV A=0x40 B=0x08 → result=0x08, div_zero=0.
- Bus stall: bus_valid low 4 cycles in LD_A, then high with 0x07 → req_a held 5 cycles, reg_A=0x07, done delayed by 4 cycles.
- Ignored start: pulse start with op=10 while in EXEC of an ADD → ADD completes with alu_sel=00 throughout, no second operation runs. Back-to-back start in the done cycle → new LD_A begins the following cycle.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: ALU-side sequencer for the shared CPU bus.
// Fetches operands A and B from the bus and holds the ALU select steady.
// Gives the ALU one execute cycle, then enables it onto the bus and captures the result.
// A divide by zero skips the ALU and returns an all-ones result with a sticky flag.
module alu_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             bus_valid,
    output logic             req_a,
    output logic             req_b,
    output logic [WIDTH-1:0] reg_A,
    output logic [WIDTH-1:0] reg_B,
    output logic [1:0]       alu_sel,
    output logic             alu_en,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             div_zero,
    output logic             busy
);

    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LD_A = 3'd1,
        LD_B = 3'd2,
        EXEC = 3'd3,
        RD   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] reg_a_q, reg_b_q, result_q;
    logic             req_a_q, req_b_q, alu_en_q, busy_q;
    logic             done_q, div_zero_q;
    logic             div_by_zero;

    // The bypass case: operand B arrives as zero for a divide.
    assign div_by_zero = (op_q == OP_DIV) && (bus_in == '0);

    // Next-state decode; waits on bus_valid in the two load states.
    always_comb begin
        // NOTE: default assignment first so every path drives state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = LD_A;
            LD_A:    if (bus_valid) state_d = LD_B;
            LD_B:    if (bus_valid) state_d = div_by_zero ? IDLE : EXEC;
            EXEC:    state_d = RD;
            RD:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, datapath registers, and outputs registered from the next state.
    always_ff @(posedge clk) begin
        // NOTE: clr is sampled synchronously and wins over every other input.
        if (clr) begin
            state_q    <= IDLE;
            op_q       <= '0;
            reg_a_q    <= '0;
            reg_b_q    <= '0;
            result_q   <= '0;
            req_a_q    <= 1'b0;
            req_b_q    <= 1'b0;
            alu_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register updates from pre-edge values.
            state_q  <= state_d;
            req_a_q  <= (state_d == LD_A);
            req_b_q  <= (state_d == LD_B);
            alu_en_q <= (state_d == RD);
            busy_q   <= (state_d != IDLE);
            done_q   <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (start) op_q <= op;
                end
                LD_A: begin
                    if (bus_valid) reg_a_q <= bus_in;
                end
                LD_B: begin
                    if (bus_valid) begin
                        reg_b_q <= bus_in;
                        if (div_by_zero) begin
                            result_q   <= '1;
                            div_zero_q <= 1'b1;
                            done_q     <= 1'b1;
                        end
                    end
                end
                RD: begin
                    // The ALU drives the bus here, so bus_valid is not consulted.
                    result_q   <= bus_in;
                    div_zero_q <= 1'b0;
                    done_q     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // alu_sel tracks the latched op and only returns to 0 on clr.
    assign alu_sel  = op_q;
    assign req_a    = req_a_q;
    assign req_b    = req_b_q;
    assign alu_en   = alu_en_q;
    assign busy     = busy_q;
    assign reg_A    = reg_a_q;
    assign reg_B    = reg_b_q;
    assign result   = result_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl.
// A simple registered ALU model sits on the bus.
// Expected results, flags and latencies come from the operation's arithmetic and the documented cycle counts.
module tb_alu_seq_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         clr;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] bus_in;
    logic         bus_valid;
    logic         req_a, req_b, alu_en, done, div_zero, busy;
    logic [W-1:0] reg_A, reg_B, result;
    logic [1:0]   alu_sel;

    logic [W-1:0] tb_bus;
    logic [W-1:0] alu_q;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .op        (op),
        .bus_in    (bus_in),
        .bus_valid (bus_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .reg_A     (reg_A),
        .reg_B     (reg_B),
        .alu_sel   (alu_sel),
        .alu_en    (alu_en),
        .result    (result),
        .done      (done),
        .div_zero  (div_zero),
        .busy      (busy)
    );

    // Arithmetic of the ALU on the bus, modulo 2^W.
    function automatic logic [W-1:0] alu_f(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int t;
        case (o)
            2'b00:   t = int'(a) + int'(b);
            2'b01:   t = int'(a) - int'(b);
            2'b10:   t = int'(a) * int'(b);
            default: t = (b == 0) ? 255 : int'(a) / int'(b);
        endcase
        return t[W-1:0];
    endfunction

    // ALU model: recomputes from its inputs every cycle and drives the bus when enabled.
    always @(posedge clk) alu_q <= alu_f(alu_sel, reg_A, reg_B);
    assign bus_in = alu_en ? alu_q : tb_bus;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one operation starting from a negedge and checks it end to end.
    // Operand-load stalls add cycles; ign pulses start with op=10 during EXEC.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int stall_a, input int stall_b, input bit ign);
        int edges   = 0;
        int n_req_a = 0;
        int n_en    = 0;
        int sel_err = 0;
        int sa      = stall_a;
        int sb      = stall_b;
        bit dz      = (o == 2'b11) && (b == 0);
        int exp_lat = (dz ? 2 : 4) + stall_a + stall_b;

        op    = o;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", {31'b0, busy}, 1);
        check("start_req_a", {31'b0, req_a}, 1);
        while (edges < 60) begin
            if (ign && busy && !req_a && !req_b && !alu_en) begin
                start = 1'b1;
                op    = 2'b10;
            end else begin
                start = 1'b0;
            end
            if (req_a) begin
                if (sa > 0) begin bus_valid = 1'b0; tb_bus = W'($urandom); sa--; end
                else        begin bus_valid = 1'b1; tb_bus = a; end
            end else if (req_b) begin
                if (sb > 0) begin bus_valid = 1'b0; tb_bus = W'($urandom); sb--; end
                else        begin bus_valid = 1'b1; tb_bus = b; end
            end else begin
                bus_valid = 1'($urandom);
                tb_bus    = W'($urandom);
            end
            @(negedge clk);
            if (req_a) n_req_a++;
            if (alu_en) n_en++;
            if (busy && alu_sel != o) sel_err++;
            if (done) break;
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        check("done_seen", {31'b0, done}, 1);
        check("latency", edges, exp_lat);
        check("result", {24'b0, result}, {24'b0, alu_f(o, a, b)});
        check("div_zero", {31'b0, div_zero}, {31'b0, dz});
        check("reg_A", {24'b0, reg_A}, {24'b0, a});
        check("reg_B", {24'b0, reg_B}, {24'b0, b});
        check("alu_en_cycles", n_en, dz ? 0 : 1);
        check("req_a_cycles", n_req_a, stall_a + 1);
        check("alu_sel_stable", sel_err, 0);
        check("done_busy", {31'b0, busy}, 0);
    endtask

    // One idle cycle after an operation: nothing restarts and the outputs hold.
    task automatic idle_check(input logic [W-1:0] exp_res, input bit exp_dz);
        @(negedge clk);
        check("idle_busy", {31'b0, busy}, 0);
        check("idle_done", {31'b0, done}, 0);
        check("idle_result", {24'b0, result}, {24'b0, exp_res});
        check("idle_dz", {31'b0, div_zero}, {31'b0, exp_dz});
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;

        clr       = 1'b1;
        start     = 1'b0;
        op        = 2'b00;
        bus_valid = 1'b0;
        tb_bus    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_result", {24'b0, result}, 0);
        check("rst_regs", {16'b0, reg_A, reg_B}, 0);
        check("rst_ctrl", {27'b0, req_a, req_b, alu_en, alu_sel}, 0);
        clr = 1'b0;

        // Directed operations; consecutive calls start in the done cycle.
        run_op(2'b00, 8'h2C, 8'h15, 0, 0, 1'b0);
        run_op(2'b01, 8'h03, 8'h05, 0, 0, 1'b0);
        run_op(2'b10, 8'h10, 8'h11, 0, 0, 1'b0);
        run_op(2'b11, 8'h40, 8'h00, 0, 0, 1'b0);
        idle_check(8'hFF, 1'b1);
        run_op(2'b11, 8'h40, 8'h08, 0, 0, 1'b0);
        run_op(2'b00, 8'h07, 8'h01, 4, 0, 1'b0);
        run_op(2'b00, 8'h33, 8'h44, 0, 0, 1'b1);
        idle_check(8'h77, 1'b0);

        // Randomized operations, including stalls and zero divisors.
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom);
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            run_op(ro, ra, rb, $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom));
            if ($urandom_range(0, 1) == 1) idle_check(alu_f(ro, ra, rb), (ro == 2'b11) && (rb == 0));
        end

        // Reset in the middle of an operation, while in LD_B.
        op    = 2'b00;
        start = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        bus_valid = 1'b1;
        tb_bus    = 8'h12;
        @(posedge clk); #1;
        check("mid_req_b", {31'b0, req_b}, 1);
        check("mid_reg_A", {24'b0, reg_A}, 32'h12);
        bus_valid = 1'b0;
        clr       = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_regs", {16'b0, reg_A, reg_B}, 0);
        check("mid_rst_result", {24'b0, result}, 0);
        check("mid_rst_flags", {28'b0, done, div_zero, req_a, req_b}, 0);

        // Back in IDLE: a fresh operation runs with normal latency.
        run_op(2'b01, 8'h80, 8'h01, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
